vector_result_packer: RTL and testbench

Collects per-element results from the vector ALU lanes and packs them into a full destination-register line for writeback to the vector register file. It sits directly downstream of the vector ALU. Per instruction it accepts one result per handshake, truncated to the current SEW or to one bit for mask-producing operations. Masked-off and tail positions are kept at the old vd value.

---
 rtl/vector_result_packer_if.sv | 34 +++
 rtl/vector_result_packer.sv | 157 +++++++++++++++
 tb/tb_vector_result_packer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_result_packer_if.sv
// vector_result_packer_if
// Groups the two streaming channels of the result packer:
//   elem_* : per-element results arriving from the vector ALU lanes
//   wb_*   : packed destination line leaving for the vector register file
// Modports:
//   master : the environment (ALU side drives elements, regfile side drives wb_ready)
//   slave  : the packer itself
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready are both 1. Once valid is raised, the producer holds
// valid and its payload stable until the transfer. ready may change freely
// and never depends combinationally on valid.
interface vector_result_packer_if #(
  parameter int VLEN        = 512,
  parameter int LONGEST_LEN = 64
);
  logic                   elem_valid;
  logic                   elem_ready;
  logic [LONGEST_LEN-1:0] elem_result;
  logic                   elem_mask;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [VLEN-1:0]        wb_data;

  modport master (
    output elem_valid, elem_result, elem_mask, wb_ready,
    input  elem_ready, wb_valid, wb_data
  );

  modport slave (
    input  elem_valid, elem_result, elem_mask, wb_ready,
    output elem_ready, wb_valid, wb_data
  );
endinterface

// File: rtl/vector_result_packer.sv
// vector_result_packer
// Collects per-element vector ALU results and packs them into one VLEN-bit
// destination line. Masked-off and tail elements keep the old vd value.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin an instruction (only looked at in IDLE)
//   vl, cur_vsew, vm, is_mask_operation, vd_old : instruction setup, latched at start
//   flush             : synchronous abort back to IDLE, highest priority
//   bus (slave)       : elem_* input channel and wb_* output channel
//   busy              : instruction in flight (state != IDLE)
//   state_dbg         : raw FSM state for observation
module vector_result_packer #(
  parameter int VLEN        = 512,
  parameter int LONGEST_LEN = 64,
  parameter int VL_WIDTH    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [VL_WIDTH-1:0] vl,
  input  logic [2:0]          cur_vsew,
  input  logic                vm,
  input  logic                is_mask_operation,
  input  logic [VLEN-1:0]     vd_old,
  input  logic                flush,
  vector_result_packer_if.slave bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  localparam int SHW = $clog2(VLEN);
  // Element count of a full register at byte granularity; also the mask VLMAX.
  localparam logic [VL_WIDTH-1:0] VLMAX_BYTES = VL_WIDTH'(VLEN / 8);

  state_t              state_q, state_d;
  logic [VL_WIDTH-1:0] idx_q;
  logic [VL_WIDTH-1:0] vl_q;
  logic [1:0]          sew_q;
  logic                vm_q;
  logic                mop_q;
  logic [VLEN-1:0]     line_q;

  logic [VL_WIDTH-1:0]    vlmax;
  logic [VL_WIDTH-1:0]    vl_clamped;
  logic                   accept;
  logic                   last_elem;
  logic [LONGEST_LEN-1:0] sew_mask;
  logic [SHW-1:0]         shamt;
  logic [VLEN-1:0]        wr_mask;
  logic [VLEN-1:0]        wr_data;

  // Effective element count for the incoming instruction. An illegal vsew
  // (1xx) behaves like vl=0 so the old vd is written back untouched.
  always_comb begin
    vlmax = is_mask_operation ? VLMAX_BYTES : (VLMAX_BYTES >> cur_vsew[1:0]);
    if (cur_vsew[2])
      vl_clamped = '0;
    else if (vl > vlmax)
      vl_clamped = vlmax;
    else
      vl_clamped = vl;
  end

  assign accept    = (state_q == COLLECT) && bus.elem_valid && !flush;
  assign last_elem = (idx_q == vl_q - VL_WIDTH'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start) state_d = (vl_clamped == '0) ? WRITEBACK : COLLECT;
        COLLECT:   if (accept && last_elem) state_d = WRITEBACK;
        WRITEBACK: if (bus.wb_ready) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Placement of the current element inside the line: a bit mask and the
  // shifted result, merged into the buffer as a read-modify-write.
  always_comb begin
    case (sew_q)
      2'd0:    sew_mask = LONGEST_LEN'(8'hFF);
      2'd1:    sew_mask = LONGEST_LEN'(16'hFFFF);
      2'd2:    sew_mask = LONGEST_LEN'(32'hFFFF_FFFF);
      default: sew_mask = '1;
    endcase
    if (mop_q) begin
      shamt   = SHW'(idx_q);
      wr_mask = VLEN'(1'b1) << shamt;
      wr_data = VLEN'(bus.elem_result[0]) << shamt;
    end else begin
      // idx * SEW bits, with SEW = 8 << sew
      shamt   = SHW'(idx_q) << ({1'b0, sew_q} + 3'd3);
      wr_mask = VLEN'(sew_mask) << shamt;
      wr_data = VLEN'(bus.elem_result & sew_mask) << shamt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vl_q   <= '0;
      sew_q  <= '0;
      vm_q   <= 1'b0;
      mop_q  <= 1'b0;
      line_q <= '0;
    end else if (flush) begin
      idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vl_q   <= vl_clamped;
            sew_q  <= cur_vsew[1:0];
            vm_q   <= vm;
            mop_q  <= is_mask_operation;
            line_q <= vd_old;
            idx_q  <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            idx_q <= idx_q + VL_WIDTH'(1);
            // Mask-undisturbed: inactive elements leave the old vd bits alone.
            if (vm_q || bus.elem_mask)
              line_q <= (line_q & ~wr_mask) | wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.elem_ready = (state_q == COLLECT);
  assign bus.wb_valid   = (state_q == WRITEBACK);
  assign bus.wb_data    = line_q;
  assign busy           = (state_q != IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_vector_result_packer.sv
// tb_vector_result_packer
// Self-checking bench for vector_result_packer: directed scenarios plus
// randomized instructions compared against a behavioural line model.
module tb_vector_result_packer;
  localparam int VLEN = 512;
  localparam int LL   = 64;
  localparam int VLW  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start;
  logic [VLW-1:0]  vl;
  logic [2:0]      vsew;
  logic            vm;
  logic            mop;
  logic [VLEN-1:0] vd_old;
  logic            flush;
  logic            busy;
  logic [1:0]      state_dbg;

  vector_result_packer_if #(.VLEN(VLEN), .LONGEST_LEN(LL)) bus ();

  vector_result_packer #(.VLEN(VLEN), .LONGEST_LEN(LL), .VL_WIDTH(VLW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .vl                (vl),
    .cur_vsew          (vsew),
    .vm                (vm),
    .is_mask_operation (mop),
    .vd_old            (vd_old),
    .flush             (flush),
    .bus               (bus.slave),
    .busy              (busy),
    .state_dbg         (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [VLEN-1:0] exp_q[$];
  logic [LL-1:0]   res [64];
  logic            msk [64];

  int              got_lat;
  int              got_cnt;
  logic            got_timeout;
  logic            stall_ok;
  logic            got_after;
  logic [VLEN-1:0] got_data;

  // ---------------- reference model ----------------
  function automatic int model_count(int vl_i, int vsew_i, bit mop_i);
    int vlmax;
    if (vsew_i > 3) return 0;
    vlmax = mop_i ? VLEN / 8 : VLEN / (8 << vsew_i);
    return (vl_i > vlmax) ? vlmax : vl_i;
  endfunction

  function automatic logic [VLEN-1:0] model_line(int vl_i, int vsew_i, bit vm_i, bit mop_i,
                                                 logic [VLEN-1:0] old);
    logic [VLEN-1:0] line;
    int n;
    int w;
    line = old;
    n = model_count(vl_i, vsew_i, mop_i);
    w = (vsew_i > 3) ? 8 : (8 << vsew_i);
    for (int i = 0; i < n; i++) begin
      if (vm_i || msk[i]) begin
        if (mop_i) line[i] = res[i][0];
        else for (int b = 0; b < w; b++) line[i*w + b] = res[i][b];
      end
    end
    return line;
  endfunction

  function automatic logic [VLEN-1:0] rand_line();
    logic [VLEN-1:0] l;
    for (int i = 0; i < VLEN/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic fill_random_elems();
    for (int i = 0; i < 64; i++) begin
      res[i] = {$urandom, $urandom};
      msk[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- driver ----------------
  // bubble: 0 = valid every cycle, 1 = every other cycle, 2 = random
  // stall : cycles wb_ready is held low after wb_valid appears
  task automatic drive_instr(input int vl_i, input int vsew_i, input bit vm_i, input bit mop_i,
                             input logic [VLEN-1:0] old, input int bubble, input int stall);
    int  k;
    int  cyc;
    bit  hs;
    bit  drive_now;
    start  = 1'b1;
    vl     = VLW'(vl_i);
    vsew   = 3'(vsew_i);
    vm     = vm_i;
    mop    = mop_i;
    vd_old = old;
    @(posedge clk); #1;
    start  = 1'b0;
    vd_old = rand_line();   // latched at start; later changes must not matter
    cyc = 1;
    k   = 0;
    while (bus.wb_valid !== 1'b1 && cyc < 400) begin
      case (bubble)
        0:       drive_now = 1'b1;
        1:       drive_now = (cyc % 2 == 0);
        default: drive_now = 1'($urandom_range(0, 1));
      endcase
      if (k < 64 && drive_now) begin
        bus.elem_valid  = 1'b1;
        bus.elem_result = res[k];
        bus.elem_mask   = msk[k];
      end else begin
        bus.elem_valid  = 1'b0;
        bus.elem_result = {$urandom, $urandom};
        bus.elem_mask   = 1'($urandom_range(0, 1));
      end
      hs = bus.elem_valid && bus.elem_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    bus.elem_valid = 1'b0;
    got_lat     = cyc;
    got_cnt     = k;
    got_timeout = (bus.wb_valid !== 1'b1);
    got_data    = bus.wb_data;
    stall_ok    = 1'b1;
    for (int s = 0; s < stall; s++) begin
      bus.wb_ready = 1'b0;
      @(posedge clk); #1;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== got_data) stall_ok = 1'b0;
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    got_after = bus.wb_valid | busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.elem_ready !== 1'b0 || bus.wb_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b wb_valid=%b busy=%b exp 0 0 0",
               bus.elem_ready, bus.wb_valid, busy);
    end
    checks++;
    if (bus.wb_data !== '0) begin
      errors++;
      $display("FAIL reset_wb_data got %h exp 0", bus.wb_data);
    end
  endtask

  task automatic test_packing();
    logic [VLEN-1:0] ones;
    ones = '1;
    res[0] = 64'h11; res[1] = 64'h22; res[2] = 64'h33; res[3] = 64'h44;
    for (int i = 0; i < 4; i++) msk[i] = 1'b0;
    drive_instr(4, 0, 1'b1, 1'b0, ones, 0, 0);
    checks++;
    if (got_data[31:0] !== 32'h44332211) begin
      errors++;
      $display("FAIL pack_low got %h exp 44332211", got_data[31:0]);
    end
    checks++;
    if (got_data[VLEN-1:32] !== ones[VLEN-1:32]) begin
      errors++;
      $display("FAIL pack_tail got %h exp all ones", got_data[VLEN-1:32]);
    end
    checks++;
    if (got_lat !== 5) begin
      errors++;
      $display("FAIL pack_latency got %0d exp 5", got_lat);
    end
  endtask

  task automatic test_masking();
    logic [VLEN-1:0] zero;
    zero = '0;
    res[0] = 64'hA; res[1] = 64'hB; res[2] = 64'hC;
    msk[0] = 1'b1;  msk[1] = 1'b0;  msk[2] = 1'b1;
    drive_instr(3, 2, 1'b0, 1'b0, zero, 0, 0);
    checks++;
    if (got_data[95:0] !== {32'hC, 32'h0, 32'hA} || got_data[VLEN-1:96] !== zero[VLEN-1:96]) begin
      errors++;
      $display("FAIL masking got %h exp 0000000c000000000000000a", got_data[95:0]);
    end
  endtask

  task automatic test_mask_op();
    logic [VLEN-1:0] zero;
    zero = '0;
    res[0] = 64'hF1; res[1] = 64'hF0; res[2] = 64'h3; res[3] = 64'h81; res[4] = 64'hFE;
    for (int i = 0; i < 5; i++) msk[i] = 1'b0;
    drive_instr(5, 0, 1'b1, 1'b1, zero, 0, 0);
    checks++;
    if (got_data[4:0] !== 5'b01101 || got_data[VLEN-1:5] !== zero[VLEN-1:5]) begin
      errors++;
      $display("FAIL mask_op got %b exp 01101 with zero upper", got_data[4:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [VLEN-1:0] old;
    fill_random_elems();
    old = rand_line();
    exp_q.push_back(model_line(10, 1, 1'b0, 1'b0, old));
    drive_instr(10, 1, 1'b0, 1'b0, old, 1, 3);
    checks++;
    if (got_cnt !== 10 || got_timeout) begin
      errors++;
      $display("FAIL bp_count got %0d timeout=%b exp 10", got_cnt, got_timeout);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL bp_stall got unstable wb exp held 3 cycles");
    end
    checks++;
    if (got_data !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_data got %h exp %h", got_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    checks++;
    if (got_after !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got busy/wb_valid=%b exp 0", got_after);
    end
  endtask

  task automatic test_vl_zero();
    logic [VLEN-1:0] old;
    fill_random_elems();
    old = rand_line();
    drive_instr(0, 1, 1'b1, 1'b0, old, 0, 0);
    checks++;
    if (got_data !== old || got_lat !== 1) begin
      errors++;
      $display("FAIL vl_zero got lat=%0d data=%h exp lat=1 data=%h", got_lat, got_data, old);
    end
  endtask

  task automatic test_clamp();
    logic [VLEN-1:0] old;
    fill_random_elems();
    old = rand_line();
    drive_instr(100, 3, 1'b1, 1'b0, old, 0, 0);
    checks++;
    if (got_cnt !== 8 || got_lat !== 9) begin
      errors++;
      $display("FAIL clamp_count got cnt=%0d lat=%0d exp cnt=8 lat=9", got_cnt, got_lat);
    end
    checks++;
    if (got_data !== model_line(100, 3, 1'b1, 1'b0, old)) begin
      errors++;
      $display("FAIL clamp_data got %h", got_data);
    end
  endtask

  task automatic test_illegal_vsew();
    logic [VLEN-1:0] old;
    fill_random_elems();
    old = rand_line();
    drive_instr(10, 5, 1'b1, 1'b0, old, 0, 0);
    checks++;
    if (got_data !== old || got_lat !== 1) begin
      errors++;
      $display("FAIL illegal_vsew got lat=%0d data=%h exp lat=1 data=%h", got_lat, got_data, old);
    end
  endtask

  task automatic test_flush();
    logic [VLEN-1:0] old;
    bit saw_wb;
    fill_random_elems();
    old = rand_line();
    start = 1'b1; vl = 7'd4; vsew = 3'd0; vm = 1'b1; mop = 1'b0; vd_old = old;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.elem_valid = 1'b1; bus.elem_result = res[i];
      @(posedge clk); #1;
    end
    flush = 1'b1; bus.elem_result = res[2];
    @(posedge clk); #1;
    flush = 1'b0; bus.elem_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.elem_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got busy=%b ready=%b wb_valid=%b exp 0 0 0",
               busy, bus.elem_ready, bus.wb_valid);
    end
    saw_wb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.wb_valid !== 1'b0) saw_wb = 1'b1;
    end
    checks++;
    if (saw_wb) begin
      errors++;
      $display("FAIL flush_no_wb got wb_valid=1 exp 0");
    end
    fill_random_elems();
    old = rand_line();
    drive_instr(4, 0, 1'b1, 1'b0, old, 0, 0);
    checks++;
    if (got_data !== model_line(4, 0, 1'b1, 1'b0, old) || got_lat !== 5) begin
      errors++;
      $display("FAIL flush_restart got lat=%0d data=%h", got_lat, got_data);
    end
  endtask

  task automatic test_async_reset();
    bit saw_wb;
    fill_random_elems();
    start = 1'b1; vl = 7'd8; vsew = 3'd0; vm = 1'b1; mop = 1'b0; vd_old = rand_line();
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.elem_valid = 1'b1; bus.elem_result = res[i];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.elem_ready !== 1'b0 || bus.wb_valid !== 1'b0 || busy !== 1'b0 || bus.wb_data !== '0) begin
      errors++;
      $display("FAIL async_reset got ready=%b wb_valid=%b busy=%b data_nonzero=%b exp 0 0 0 0",
               bus.elem_ready, bus.wb_valid, busy, |bus.wb_data);
    end
    bus.elem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_wb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.wb_valid !== 1'b0 || busy !== 1'b0) saw_wb = 1'b1;
    end
    checks++;
    if (saw_wb) begin
      errors++;
      $display("FAIL async_reset_no_wb got activity after reset exp idle");
    end
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] old;
    for (int n = 0; n < 2; n++) begin
      fill_random_elems();
      old = rand_line();
      exp_q.push_back(model_line(6, 2, 1'b0, 1'b0, old));
      drive_instr(6, 2, 1'b0, 1'b0, old, 0, 0);
      checks++;
      if (got_data !== exp_q[0] || got_lat !== 7 || got_after !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back_%0d got lat=%0d after=%b data=%h exp lat=7 after=0 data=%h",
                 n, got_lat, got_after, got_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [VLEN-1:0] old;
    int r, vl_i, vsew_i, bubble, stall;
    bit vm_i, mop_i;
    for (int n = 0; n < 25; n++) begin
      fill_random_elems();
      old    = rand_line();
      r      = $urandom_range(0, 9);
      vsew_i = (r <= 7) ? (r % 4) : (4 + r - 8);
      vl_i   = $urandom_range(0, 100);
      vm_i   = 1'($urandom_range(0, 1));
      mop_i  = ($urandom_range(0, 3) == 0);
      bubble = $urandom_range(0, 2);
      stall  = $urandom_range(0, 3);
      exp_q.push_back(model_line(vl_i, vsew_i, vm_i, mop_i, old));
      drive_instr(vl_i, vsew_i, vm_i, mop_i, old, bubble, stall);
      checks++;
      if (got_timeout || got_data !== exp_q[0] ||
          got_cnt !== model_count(vl_i, vsew_i, mop_i) || !stall_ok) begin
        errors++;
        $display("FAIL random_%0d vl=%0d vsew=%0d vm=%b mop=%b got cnt=%0d stall_ok=%b data=%h exp cnt=%0d data=%h",
                 n, vl_i, vsew_i, vm_i, mop_i, got_cnt, stall_ok, got_data,
                 model_count(vl_i, vsew_i, mop_i), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    start = 1'b0; vl = '0; vsew = '0; vm = 1'b0; mop = 1'b0; vd_old = '0; flush = 1'b0;
    bus.elem_valid = 1'b0; bus.elem_result = '0; bus.elem_mask = 1'b0; bus.wb_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_packing();
    test_masking();
    test_mask_op();
    test_backpressure();
    test_vl_zero();
    test_clamp();
    test_illegal_vsew();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
